// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue plus launch controller feeding the UART transmitter.
// Bytes pushed by the host are held in a small circular buffer. They are handed
// to the transmitter one at a time through the trmt/tx_data/tx_done handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_ovf,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy,
  output logic          trmt,
  output logic [7:0]    tx_data,
  input  logic          tx_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          trmt_q, trmt_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          full_w;
  logic          empty_w;
  logic          pop;
  logic          push;
  logic          drop;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A pop frees a slot in the same cycle, so a push into a full queue is still
  // accepted when the controller is draining the head; flush blocks both.
  assign pop  = (state_q == IDLE) && !empty_w && !flush;
  assign push = wr_en && !flush && (!full_w || pop);
  assign drop = wr_en && !flush && full_w && !pop;

  // Next-state logic for pointers, occupancy, overflow flag and launch FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    trmt_d     = trmt_q;
    tx_data_d  = tx_data_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        trmt_d = 1'b0;
        if (pop) begin
          tx_data_d = mem[rd_ptr_q];
          trmt_d    = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        // tx_done may still be high from the previous byte here, so ignore it.
        trmt_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        trmt_d = 1'b0;
        if (tx_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        trmt_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Control and status registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      trmt_q     <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      trmt_q     <= trmt_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Byte storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);
  assign trmt     = trmt_q;
  assign tx_data  = tx_data_q;

endmodule
